program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder for the microcontroller's program-memory load port (LE/LA/LI) during the LOAD stage.
- Receives a byte stream over a valid/ready handshake from the host link: header, instruction bytes, checksum.
- Assembles 12-bit instructions and issues one single-cycle program-memory write per instruction.
- Signals load completion, or a framing/checksum error, to the core's LOAD-state logic.

Parameters:
- MAX_LEN, 10, maximum instructions per program; legal range 1..255.
- ADDR_W, 8, width of load_addr; matches the program-memory address width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  single-cycle pulse; begins a new load session
- in_data  input  8  incoming byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- load_en  output  1  program-memory load enable (drives LE)
- load_addr  output  ADDR_W  program-memory load address (drives LA)
- load_instr  output  12  program-memory load data (drives LI)
- load_done  output  1  program fully written and checksum good; level signal
- busy  output  1  session in progress (HDR through CHK)
- err  output  1  session aborted on error; level signal

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers (count, addr, instr, xor accumulator) clear to 0.
  - Reset asserted mid-session aborts it immediately; no partial write completes after reset.
- Byte transfer: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered/state-decoded output and never depends combinationally on in_valid.
- IDLE: in_ready=0; start=1 -> HDR.
- HDR: in_ready=1. Accepted byte is N.
  - N==0 or N>MAX_LEN -> ERR.
  - Otherwise: store N, addr<=0, xor<=0 -> LO.
- LO: in_ready=1. Accepted byte -> instr[7:0]; xor^=byte -> HI.
- HI: in_ready=1. Accepted byte:
  - byte[7:4]!=0 -> ERR.
  - Otherwise instr[11:8]<=byte[3:0]; xor^=byte -> WRITE.
- WRITE: in_ready=0.
  - load_en=1 for exactly one cycle, with load_addr=addr and load_instr=instr stable in that same cycle.
  - Next cycle: addr==N-1 -> CHK; otherwise addr<=addr+1 -> LO.
- CHK: in_ready=1. Accepted byte equals xor -> DONE; otherwise -> ERR.
- DONE: load_done=1 and busy=0. Held until start=1, which clears load_done and -> HDR.
- ERR: err=1 and busy=0; load_en never asserts. Held until start=1, which clears err and -> HDR.
- start while busy=1 is ignored.
- load_en is 0 in every state except WRITE. load_addr and load_instr hold their last values outside WRITE.
- Throughput: minimum 3 cycles per instruction (LO, HI, WRITE) when in_valid is held high. Total minimum session length is 3N+2 cycles from HDR entry to DONE.
- No address wrap is possible: addr never exceeds MAX_LEN-1 <= 254.
- Gaps on in_valid stall the current state indefinitely; there is no timeout.
- Writes already issued before an error stay in program memory. err is the core's indication that memory contents are invalid.

Test Plan:
- Nominal load: reset, start, bytes 0x02,0x23,0x01,0xAB,0x00,0x89.
  - Write 1: load_en pulses with addr 0x00, instr 0x123.
  - Write 2: load_en pulses with addr 0x01, instr 0x0AB.
  - Then load_done=1, err=0, busy=0; exactly two load_en cycles in total.
- Bad header: start, byte 0x00 -> err=1, no load_en. Then start, byte 0x0B (with MAX_LEN=10) -> err=1, no load_en.
- Framing error: start, bytes 0x01,0x55,0x1F -> err=1 immediately after the HI byte; load_en never asserts.
- Checksum error: nominal sequence with final byte 0x88 -> both writes occur, then err=1 and load_done=0.
- Backpressure and gaps: nominal sequence with in_valid low for 3 cycles between every byte.
  - Same writes and result as the nominal case.
  - in_ready=0 throughout every WRITE cycle.
  - No byte is lost or duplicated.
- Async reset mid-session: drive rst=0 between the LO and HI bytes, off the clock edge.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, state is IDLE and in_ready=0; a fresh nominal session then completes correctly.

Source files
------------

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  program_loader_if
//  ----------------------------------------------------------------------------
//  Bundles the host byte stream and the program-memory load port of the
//  program loader.
//    start       : session start pulse (host -> loader)
//    in_data     : incoming byte        (host -> loader)
//    in_valid    : in_data valid        (host -> loader)
//    in_ready    : loader accepts byte  (loader -> host)
//    load_en     : LE, one-cycle write  (loader -> core)
//    load_addr   : LA, write address    (loader -> core)
//    load_instr  : LI, 12-bit word      (loader -> core)
//    load_done   : session completed    (loader -> core)
//    busy        : session in progress  (loader -> core)
//    err         : session aborted      (loader -> core)
//  Revision: 1.0  initial release
// ============================================================================
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [11:0]       load_instr;
  logic              load_done;
  logic              busy;
  logic              err;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, load_en, load_addr, load_instr, load_done, busy, err
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, load_en, load_addr, load_instr, load_done, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  program_loader
//  ----------------------------------------------------------------------------
//  Receives a framed byte stream (length header, LO/HI instruction byte pairs,
//  XOR checksum) and issues one single-cycle program-memory write per 12-bit
//  instruction. Reports completion or framing/checksum errors as levels.
//  Ports:
//    clk    : system clock, rising edge
//    rst_n  : asynchronous reset, active low
//    bus    : program_loader_if.slave (byte stream in, LE/LA/LI out, status)
//  Revision: 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int MAX_LEN = 10,
  parameter int ADDR_W  = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  program_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       instr_q, instr_d;
  logic [7:0]        xor_q, xor_d;
  // Separate output registers so LA/LI hold the last written word while the
  // working address/instruction registers advance for the next instruction.
  logic [ADDR_W-1:0] la_q, la_d;
  logic [11:0]       li_q, li_d;

  logic ready;
  logic accept;
  logic last_instr;

  // in_ready is decoded from state only, never from in_valid.
  assign ready  = (state_q == S_HDR) || (state_q == S_LO) ||
                  (state_q == S_HI)  || (state_q == S_CHK);
  assign accept = ready && bus.in_valid;
  assign last_instr = (addr_q == ADDR_W'(n_q - 8'd1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    xor_d   = xor_q;
    la_d    = la_q;
    li_d    = li_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          if ((bus.in_data == 8'd0) || (32'(bus.in_data) > 32'(MAX_LEN))) begin
            state_d = S_ERR;
          end else begin
            n_d     = bus.in_data;
            addr_d  = '0;
            xor_d   = 8'd0;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          instr_d[7:0] = bus.in_data;
          xor_d        = xor_q ^ bus.in_data;
          state_d      = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          if (bus.in_data[7:4] != 4'd0) begin
            state_d = S_ERR;
          end else begin
            instr_d[11:8] = bus.in_data[3:0];
            xor_d         = xor_q ^ bus.in_data;
            // Latch the complete word into the output port for the WRITE cycle.
            la_d          = addr_q;
            li_d          = {bus.in_data[3:0], instr_q[7:0]};
            state_d       = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_instr) begin
          state_d = S_CHK;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LO;
        end
      end
      S_CHK: begin
        if (accept) state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 8'd0;
      addr_q  <= '0;
      instr_q <= 12'd0;
      xor_q   <= 8'd0;
      la_q    <= '0;
      li_q    <= 12'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      xor_q   <= xor_d;
      la_q    <= la_d;
      li_q    <= li_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.load_en    = (state_q == S_WRITE);
  assign bus.load_addr  = la_q;
  assign bus.load_instr = li_q;
  assign bus.load_done  = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);
  assign bus.busy       = (state_q == S_HDR) || (state_q == S_LO) ||
                          (state_q == S_HI)  || (state_q == S_WRITE) ||
                          (state_q == S_CHK);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  tb_program_loader
//  ----------------------------------------------------------------------------
//  Self-checking bench: a table of directed sessions, hand-written corner
//  sequences (async reset, start while busy, DONE hold) and random sessions
//  checked against a frame-parsing reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_program_loader;
  localparam int MAX_LEN = 10;
  localparam int ADDR_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [19:0] wr_q[$];    // observed writes {addr, instr}
  logic [19:0] exp_wq[$];  // model writes
  logic [7:0]  stim[$];
  int acc_cnt   = 0;
  int rdy_viol  = 0;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.load_en) begin
      wr_q.push_back({bus.load_addr, bus.load_instr});
      if (bus.in_ready) rdy_viol++;
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (ok) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Reference: parse the frame by its rules, list the writes it implies,
  // count how many bytes the loader should consume, and decide the outcome.
  task automatic model(output int consumed, output bit done);
    int n;
    logic [7:0] x, lo, hi;
    exp_wq.delete();
    consumed = 1;
    done     = 1'b0;
    n        = int'(stim[0]);
    if (n == 0 || n > MAX_LEN) return;
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      lo = stim[1 + 2*i];
      hi = stim[2 + 2*i];
      consumed += 2;
      if (hi[7:4] != 4'd0) return;
      exp_wq.push_back({8'(i), hi[3:0], lo});
      x = x ^ lo ^ hi;
    end
    consumed++;
    done = (stim[2*n + 1] == x);
  endtask

  task automatic run_session(input string tag, input int gap, input bit poke,
                             input int exp_done_tbl, input int exp_wr_tbl);
    int  consumed, a0, w0, r0, nw;
    bit  done_m, ok, fin;
    model(consumed, done_m);
    a0 = acc_cnt; w0 = wr_q.size(); r0 = rdy_viol;
    pulse_start();
    for (int k = 0; k < consumed; k++) begin
      send(stim[k], ok);
      if (!ok) begin
        chk({tag, ".byte_timeout"}, 32'(k), 32'hFFFF_FFFF);
        break;
      end
      if (poke && k == 0) pulse_start();
      repeat (gap) tick();
    end
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.load_done || bus.err) fin = 1'b1;
    end
    chk({tag, ".finish"}, 32'(fin), 32'd1);
    chk({tag, ".done"}, 32'(bus.load_done), 32'(done_m));
    chk({tag, ".err"}, 32'(bus.err), 32'(!done_m));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
    if (exp_done_tbl >= 0) begin
      chk({tag, ".tbl_done"}, 32'(bus.load_done), 32'(exp_done_tbl));
      chk({tag, ".tbl_writes"}, 32'(wr_q.size() - w0), 32'(exp_wr_tbl));
    end
    nw = wr_q.size() - w0;
    chk({tag, ".nwrites"}, 32'(nw), 32'(exp_wq.size()));
    for (int i = 0; i < nw && i < exp_wq.size(); i++)
      chk($sformatf("%s.write%0d", tag, i), 32'(wr_q[w0 + i]), 32'(exp_wq[i]));
    chk({tag, ".accepted"}, 32'(acc_cnt - a0), 32'(consumed));
    chk({tag, ".ready_in_write"}, 32'(rdy_viol - r0), 32'd0);
  endtask

  typedef struct {
    logic [191:0] raw;   // bytes right-aligned, first byte most significant
    int           nb;
    int           gap;
    int           exp_done;
    int           exp_wr;
  } vec_t;

  vec_t tbl[7];

  task automatic load_vec(input vec_t v);
    stim.delete();
    for (int i = 0; i < v.nb; i++) stim.push_back(v.raw[8*(v.nb-1-i) +: 8]);
  endtask

  initial begin
    bit ok;
    int n, gap;
    logic [7:0] x, lo, hi;

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'd0;

    tbl[0] = '{raw: 192'h02_23_01_AB_00_89, nb: 6, gap: 0, exp_done: 1, exp_wr: 2};
    tbl[1] = '{raw: 192'h00,                nb: 1, gap: 0, exp_done: 0, exp_wr: 0};
    tbl[2] = '{raw: 192'h0B,                nb: 1, gap: 0, exp_done: 0, exp_wr: 0};
    tbl[3] = '{raw: 192'h01_55_1F,          nb: 3, gap: 0, exp_done: 0, exp_wr: 0};
    tbl[4] = '{raw: 192'h02_23_01_AB_00_88, nb: 6, gap: 0, exp_done: 0, exp_wr: 2};
    tbl[5] = '{raw: 192'h02_23_01_AB_00_89, nb: 6, gap: 3, exp_done: 1, exp_wr: 2};
    tbl[6] = '{raw: 192'h01_34_0F_3B,       nb: 4, gap: 1, exp_done: 1, exp_wr: 1};

    // Reset state
    repeat (3) tick();
    chk("rst.load_en", 32'(bus.load_en), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.status", {29'd0, bus.load_done, bus.busy, bus.err}, 32'd0);
    chk("rst.addr_instr", {12'd0, bus.load_addr, bus.load_instr}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int t = 0; t < 7; t++) begin
      load_vec(tbl[t]);
      run_session($sformatf("tbl%0d", t), tbl[t].gap, 1'b0, tbl[t].exp_done, tbl[t].exp_wr);
    end

    // DONE is a held level
    load_vec(tbl[0]);
    run_session("hold", 0, 1'b0, 1, 2);
    repeat (5) tick();
    chk("hold.done", 32'(bus.load_done), 32'd1);
    chk("hold.busy", 32'(bus.busy), 32'd0);

    // start while busy is ignored
    load_vec(tbl[6]);
    run_session("poke", 0, 1'b1, 1, 1);

    // Async reset between LO and HI bytes, applied off the clock edge
    load_vec(tbl[0]);
    pulse_start();
    send(8'h02, ok);
    send(8'h23, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.load_en", 32'(bus.load_en), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst.status", {29'd0, bus.load_done, bus.busy, bus.err}, 32'd0);
    chk("arst.addr_instr", {12'd0, bus.load_addr, bus.load_instr}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) tick();
    chk("arst.idle_ready", 32'(bus.in_ready), 32'd0);
    chk("arst.idle_busy", 32'(bus.busy), 32'd0);
    run_session("after_rst", 0, 1'b0, 1, 2);

    // Random sessions
    for (int r = 0; r < 40; r++) begin
      stim.delete();
      n = $urandom_range(0, MAX_LEN + 2);
      stim.push_back(8'(n));
      if (n >= 1 && n <= MAX_LEN) begin
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
          lo = 8'($urandom);
          hi = ($urandom_range(0, 24) == 0) ? 8'($urandom | 32'h10) : {4'd0, 4'($urandom)};
          stim.push_back(lo);
          stim.push_back(hi);
          x = x ^ lo ^ hi;
        end
        stim.push_back(($urandom_range(0, 5) == 0) ? (x ^ 8'h5A) : x);
      end
      gap = $urandom_range(0, 2);
      run_session($sformatf("rnd%0d", r), gap, 1'b0, -1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
